// File: rtl/sdram_init_seq_checker_pkg.sv
// Shared types for the SDRAM power-up sequence checker: decoded command set,
// checker FSM state encodings and error codes.
package sdram_chk_pkg;

   typedef enum logic [2:0] {
      CMD_NOP     = 3'd0,
      CMD_PRE     = 3'd1,
      CMD_REF     = 3'd2,
      CMD_LMR     = 3'd3,
      CMD_ILLEGAL = 3'd4
   } sdram_cmd_e;

   // Plain-vector state type so the encodings stay stable for legacy tools.
   typedef logic [2:0] chk_state_e;
   localparam chk_state_e S_PWRUP = 3'd0;
   localparam chk_state_e S_TRP   = 3'd1;
   localparam chk_state_e S_TRFC  = 3'd2;
   localparam chk_state_e S_MRD   = 3'd3;
   localparam chk_state_e S_DONE  = 3'd4;
   localparam chk_state_e S_FAIL  = 3'd5;

   typedef logic [2:0] err_code_e;
   localparam err_code_e ERR_NONE      = 3'd0;
   localparam err_code_e ERR_EARLY_PRE = 3'd1;
   localparam err_code_e ERR_ILLEGAL   = 3'd2;
   localparam err_code_e ERR_TRP       = 3'd3;
   localparam err_code_e ERR_TRFC      = 3'd4;
   localparam err_code_e ERR_FEW_REF   = 3'd5;
   localparam err_code_e ERR_TIMEOUT   = 3'd6;
   localparam err_code_e ERR_DONE_EARLY = 3'd7;

   function automatic logic is_terminal(input chk_state_e s);
      return (s == S_DONE) || (s == S_FAIL);
   endfunction

endpackage

// File: rtl/sdram_init_seq_checker_if.sv
// SDRAM pin bundle as seen at the device: the controller drives it, the checker observes it.
interface sdram_init_seq_checker_if;
   // No handshake: every pin is sampled on each sdram_clk rising edge; a command
   // lasts exactly one cycle and cs_n high counts as a NOP.
   logic        sdr_cke;
   logic        sdr_cs_n;
   logic        sdr_ras_n;
   logic        sdr_cas_n;
   logic        sdr_we_n;
   logic [12:0] sdr_addr;
   logic        sdr_init_done;

   modport master (
      output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_init_done
   );

   modport slave (
      input sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_init_done
   );
endinterface

// File: rtl/sdram_init_seq_checker_cmd_decode.sv
// Combinational SDRAM command decoder; anything outside the init command set
// (ACT/RD/WR/BST) collapses to CMD_ILLEGAL.
module sdram_cmd_decode
   import sdram_chk_pkg::*;
(
   input  logic       cs_n,
   input  logic       ras_n,
   input  logic       cas_n,
   input  logic       we_n,
   output sdram_cmd_e cmd
);

   always_comb begin
      cmd = CMD_ILLEGAL;
      if (cs_n) begin
         cmd = CMD_NOP;
      end else begin
         case ({ras_n, cas_n, we_n})
            3'b111:  cmd = CMD_NOP;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_LMR;
            default: cmd = CMD_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/sdram_init_seq_checker.sv
// Monitors the SDRAM power-up command stream and reports a sticky pass/fail verdict,
// first error code, captured mode register, refresh count and init cycle count.
module sdram_init_seq_checker
   import sdram_chk_pkg::*;
#(
   parameter int unsigned MIN_NOP      = 500,
   parameter int unsigned T_RP         = 3,
   parameter int unsigned T_RFC        = 7,
   parameter int unsigned NUM_REF      = 2,
   parameter int unsigned DONE_TIMEOUT = 16
) (
   input  logic                      sdram_clk,
   input  logic                      sdram_resetn,
   sdram_init_seq_checker_if.slave   pins,
   output logic                      init_pass,
   output logic                      init_fail,
   output logic [2:0]                err_code,
   output logic [12:0]               mode_reg,
   output logic [3:0]                ref_count,
   output logic [15:0]               init_cycles,
   output logic [2:0]                chk_state
);

   localparam logic [15:0] MIN_NOP_G  = 16'(MIN_NOP);
   localparam logic [15:0] T_RP_G     = 16'(T_RP);
   localparam logic [15:0] T_RFC_G    = 16'(T_RFC);
   localparam logic [15:0] DONE_LIM_G = 16'(DONE_TIMEOUT - 1);
   localparam logic [3:0]  NUM_REF_C  = 4'(NUM_REF);

   sdram_cmd_e  cmd;
   chk_state_e  state, state_n;
   logic [15:0] gap, gap_n, gap_inc;
   logic [3:0]  ref_n;
   logic [12:0] mode_n;
   logic [15:0] cyc_n;
   logic        pass_n, fail_n;
   err_code_e   err_n, err_hit;

   sdram_cmd_decode u_decode (
      .cs_n  (pins.sdr_cs_n),
      .ras_n (pins.sdr_ras_n),
      .cas_n (pins.sdr_cas_n),
      .we_n  (pins.sdr_we_n),
      .cmd   (cmd)
   );

   assign gap_inc   = (gap == 16'hFFFF) ? gap : gap + 16'd1;
   assign chk_state = state;

   always_comb begin
      state_n = state;
      gap_n   = gap;
      ref_n   = ref_count;
      mode_n  = mode_reg;
      pass_n  = init_pass;
      fail_n  = init_fail;
      err_n   = err_code;
      err_hit = ERR_NONE;
      cyc_n   = init_cycles;

      if (!is_terminal(state) && init_cycles != 16'hFFFF) cyc_n = init_cycles + 16'd1;

      case (state)
         S_PWRUP, S_TRP, S_TRFC: begin
            // Early done outranks cke, which outranks the command itself.
            if (pins.sdr_init_done)  err_hit = ERR_DONE_EARLY;
            else if (!pins.sdr_cke)  err_hit = ERR_ILLEGAL;
            else if (cmd == CMD_NOP) gap_n = gap_inc;
            else if (state == S_PWRUP) begin
               if (cmd != CMD_PRE)          err_hit = ERR_ILLEGAL;
               else if (gap < MIN_NOP_G)    err_hit = ERR_EARLY_PRE;
               else begin
                  state_n = S_TRP;
                  gap_n   = '0;
               end
            end else if (state == S_TRP) begin
               if (cmd != CMD_REF)          err_hit = ERR_ILLEGAL;
               else if (gap < T_RP_G)       err_hit = ERR_TRP;
               else begin
                  state_n = S_TRFC;
                  gap_n   = '0;
                  ref_n   = 4'd1;
               end
            end else begin
               if (cmd == CMD_REF) begin
                  if (gap < T_RFC_G) err_hit = ERR_TRFC;
                  else begin
                     ref_n = (ref_count == 4'hF) ? ref_count : ref_count + 4'd1;
                     gap_n = '0;
                  end
               end else if (cmd == CMD_LMR) begin
                  if (gap < T_RFC_G)              err_hit = ERR_TRFC;
                  else if (ref_count < NUM_REF_C) err_hit = ERR_FEW_REF;
                  else begin
                     state_n = S_MRD;
                     gap_n   = '0;
                     mode_n  = pins.sdr_addr;
                  end
               end else begin
                  err_hit = ERR_ILLEGAL;
               end
            end
         end
         S_MRD: begin
            // A done flag in the same cycle as a bad command still counts as a pass.
            if (pins.sdr_init_done) begin
               state_n = S_DONE;
               pass_n  = 1'b1;
            end else if (!pins.sdr_cke || cmd != CMD_NOP) begin
               err_hit = ERR_ILLEGAL;
            end else if (gap >= DONE_LIM_G) begin
               err_hit = ERR_TIMEOUT;
            end else begin
               gap_n = gap_inc;
            end
         end
         default: ;
      endcase

      if (err_hit != ERR_NONE) begin
         state_n = S_FAIL;
         fail_n  = 1'b1;
         err_n   = err_hit;
         gap_n   = '0;
      end
   end

   always_ff @(posedge sdram_clk) begin
      if (!sdram_resetn) begin
         state       <= S_PWRUP;
         gap         <= '0;
         ref_count   <= '0;
         mode_reg    <= '0;
         init_pass   <= 1'b0;
         init_fail   <= 1'b0;
         err_code    <= ERR_NONE;
         init_cycles <= '0;
      end else begin
         state       <= state_n;
         gap         <= gap_n;
         ref_count   <= ref_n;
         mode_reg    <= mode_n;
         init_pass   <= pass_n;
         init_fail   <= fail_n;
         err_code    <= err_n;
         init_cycles <= cyc_n;
      end
   end

endmodule

// File: tb/tb_sdram_init_seq_checker.sv
// Scenario bench for sdram_init_seq_checker: drives init command streams and checks the
// final verdict record against expectations queued alongside the stimulus.
module tb_sdram_init_seq_checker;
  import sdram_chk_pkg::*;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_ACT = 4'b0011;

  logic        clk = 1'b0;
  logic        sdram_resetn = 1'b0;
  logic        init_pass, init_fail;
  logic [2:0]  err_code;
  logic [12:0] mode_reg;
  logic [3:0]  ref_count;
  logic [15:0] init_cycles;
  logic [2:0]  chk_state;

  int checks = 0;
  int failures = 0;
  logic [37:0] exp_q[$];
  logic [37:0] got, exp;

  sdram_init_seq_checker_if pins();

  sdram_init_seq_checker #(
    .MIN_NOP(8), .T_RP(3), .T_RFC(7), .NUM_REF(2), .DONE_TIMEOUT(16)
  ) dut (
    .sdram_clk(clk), .sdram_resetn(sdram_resetn), .pins(pins),
    .init_pass(init_pass), .init_fail(init_fail), .err_code(err_code),
    .mode_reg(mode_reg), .ref_count(ref_count), .init_cycles(init_cycles),
    .chk_state(chk_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [37:0] pack_exp(input logic p, input logic f, input logic [2:0] e,
                                           input logic [12:0] m, input logic [3:0] r,
                                           input logic [15:0] c);
    return {p, f, e, m, r, c};
  endfunction

  // driver tasks
  task automatic drive(input logic [3:0] c, input logic [12:0] a, input logic done, input logic cke);
    pins.sdr_cs_n = c[3];
    pins.sdr_ras_n = c[2];
    pins.sdr_cas_n = c[1];
    pins.sdr_we_n = c[0];
    pins.sdr_addr = a;
    pins.sdr_init_done = done;
    pins.sdr_cke = cke;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] c);
    drive(c, 13'h0, 1'b0, 1'b1);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cmd((i % 2 == 1) ? C_DES : C_NOP);
  endtask

  task automatic reset_dut();
    sdram_resetn = 1'b0;
    cmd(C_NOP);
    cmd(C_NOP);
    sdram_resetn = 1'b1;
  endtask

  // 29 cycles: 8 NOP, PRE, 3 NOP, REF, 7 NOP, REF, 7 NOP, LMR
  task automatic run_to_lmr(input logic [12:0] a);
    nops(8); cmd(C_PRE); nops(3); cmd(C_REF); nops(7); cmd(C_REF); nops(7);
    drive(C_LMR, a, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_dut();
    exp_q.push_back(pack_exp(0, 0, 3'd0, 13'h0, 4'd0, 16'd0));
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    checks++;
    if (chk_state !== S_PWRUP) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", chk_state, S_PWRUP); end
  endtask

  task automatic test_legal();
    reset_dut();
    run_to_lmr(13'h033);
    nops(3);
    checks++;
    if ({init_pass, init_fail} !== 2'b00) begin failures++; $display("FAIL legal_pending got=%b exp=00", {init_pass, init_fail}); end
    exp_q.push_back(pack_exp(1, 0, 3'd0, 13'h033, 4'd2, 16'd33));
    drive(C_NOP, 13'h0, 1'b1, 1'b1);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL legal_result got=%h exp=%h", got, exp); end
    checks++;
    if (chk_state !== S_DONE) begin failures++; $display("FAIL legal_state got=%0d exp=%0d", chk_state, S_DONE); end
  endtask

  task automatic test_early_pre();
    reset_dut();
    nops(5);
    exp_q.push_back(pack_exp(0, 1, 3'd1, 13'h0, 4'd0, 16'd6));
    cmd(C_PRE);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL early_pre got=%h exp=%h", got, exp); end
    // legal traffic after the failure must not disturb anything
    exp_q.push_back(pack_exp(0, 1, 3'd1, 13'h0, 4'd0, 16'd6));
    nops(3); cmd(C_REF); nops(7); cmd(C_REF); nops(7);
    drive(C_LMR, 13'h055, 1'b0, 1'b1);
    drive(C_NOP, 13'h0, 1'b1, 1'b1);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL early_pre_sticky got=%h exp=%h", got, exp); end
  endtask

  task automatic test_refresh_timing();
    reset_dut();
    nops(8); cmd(C_PRE); nops(3); cmd(C_REF); nops(6);
    exp_q.push_back(pack_exp(0, 1, 3'd4, 13'h0, 4'd1, 16'd20));
    cmd(C_REF);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL trfc_early got=%h exp=%h", got, exp); end

    reset_dut();
    nops(8); cmd(C_PRE); nops(3); cmd(C_REF); nops(7);
    exp_q.push_back(pack_exp(0, 1, 3'd5, 13'h0, 4'd1, 16'd21));
    drive(C_LMR, 13'h033, 1'b0, 1'b1);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL too_few_ref got=%h exp=%h", got, exp); end

    reset_dut();
    nops(8); cmd(C_PRE); nops(2);
    exp_q.push_back(pack_exp(0, 1, 3'd3, 13'h0, 4'd0, 16'd12));
    cmd(C_REF);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL trp_early got=%h exp=%h", got, exp); end
  endtask

  task automatic test_done_timing();
    reset_dut();
    run_to_lmr(13'h123);
    nops(15);
    checks++;
    if ({init_pass, init_fail} !== 2'b00) begin failures++; $display("FAIL timeout_pending got=%b exp=00", {init_pass, init_fail}); end
    exp_q.push_back(pack_exp(0, 1, 3'd6, 13'h123, 4'd2, 16'd45));
    cmd(C_NOP);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL done_timeout got=%h exp=%h", got, exp); end

    reset_dut();
    nops(2);
    exp_q.push_back(pack_exp(0, 1, 3'd7, 13'h0, 4'd0, 16'd3));
    drive(C_NOP, 13'h0, 1'b1, 1'b1);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL done_early got=%h exp=%h", got, exp); end
  endtask

  task automatic test_illegal();
    reset_dut();
    nops(8); cmd(C_PRE); nops(1);
    exp_q.push_back(pack_exp(0, 1, 3'd2, 13'h0, 4'd0, 16'd11));
    cmd(C_ACT);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL act_in_trp got=%h exp=%h", got, exp); end

    reset_dut();
    nops(2);
    exp_q.push_back(pack_exp(0, 1, 3'd2, 13'h0, 4'd0, 16'd3));
    drive(C_NOP, 13'h0, 1'b0, 1'b0);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL cke_low got=%h exp=%h", got, exp); end
    checks++;
    if (chk_state !== S_FAIL) begin failures++; $display("FAIL cke_low_state got=%0d exp=%0d", chk_state, S_FAIL); end
  endtask

  task automatic test_priority();
    reset_dut();
    nops(1);
    exp_q.push_back(pack_exp(0, 1, 3'd7, 13'h0, 4'd0, 16'd2));
    drive(C_ACT, 13'h0, 1'b1, 1'b0);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL prio_done_over_cke got=%h exp=%h", got, exp); end

    reset_dut();
    run_to_lmr(13'h1FF);
    exp_q.push_back(pack_exp(1, 0, 3'd0, 13'h1FF, 4'd2, 16'd30));
    drive(C_ACT, 13'h0, 1'b1, 1'b1);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL prio_done_over_cmd got=%h exp=%h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] a;
    reset_dut();
    nops(8); cmd(C_PRE); nops(3); cmd(C_REF); nops(2);
    reset_dut();
    exp_q.push_back(pack_exp(0, 0, 3'd0, 13'h0, 4'd0, 16'd0));
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midseq_reset got=%h exp=%h", got, exp); end
    a = 13'($urandom_range(0, 8191));
    run_to_lmr(a);
    nops(3);
    exp_q.push_back(pack_exp(1, 0, 3'd0, a, 4'd2, 16'd33));
    drive(C_NOP, 13'h0, 1'b1, 1'b1);
    got = {init_pass, init_fail, err_code, mode_reg, ref_count, init_cycles};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin failures++; $display("FAIL restart_pass got=%h exp=%h", got, exp); end
  endtask

  initial begin
    pins.sdr_cke = 1'b0;
    pins.sdr_cs_n = 1'b1;
    pins.sdr_ras_n = 1'b1;
    pins.sdr_cas_n = 1'b1;
    pins.sdr_we_n = 1'b1;
    pins.sdr_addr = '0;
    pins.sdr_init_done = 1'b0;
    test_reset();
    test_legal();
    test_early_pre();
    test_refresh_timing();
    test_done_timing();
    test_illegal();
    test_priority();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
